// File: rtl/ac_pkg.sv
// Shared definitions for the accumulator computer: widths, opcodes and sequencer states.
package ac_pkg;

   localparam int unsigned AC_DATA_W = 8;
   localparam int unsigned AC_ADDR_W = 5;
   localparam int unsigned AC_OPC_W  = 3;

   localparam logic [2:0] OP_NOP = 3'd0;
   localparam logic [2:0] OP_LDA = 3'd1;
   localparam logic [2:0] OP_STA = 3'd2;
   localparam logic [2:0] OP_ADD = 3'd3;
   localparam logic [2:0] OP_SUB = 3'd4;
   localparam logic [2:0] OP_JMP = 3'd5;
   localparam logic [2:0] OP_JZ  = 3'd6;
   localparam logic [2:0] OP_HLT = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_MEM_RD = 3'd3,
      ST_EXEC   = 3'd4,
      ST_MEM_WR = 3'd5,
      ST_HALT   = 3'd6
   } state_e;

endpackage

// File: rtl/ac_alu.sv
// Combinational add/subtract for the accumulator; carry_o is the borrow when subtracting.
module ac_alu #(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         sub_i,
   output logic [W-1:0] result_o,
   output logic         carry_o,
   output logic         zero_o
);

   logic [W:0] ext;

   // Bit W of the widened difference is set exactly when a_i < b_i.
   always_comb begin
      ext = '0;
      if (sub_i) ext = {1'b0, a_i} - {1'b0, b_i};
      else       ext = {1'b0, a_i} + {1'b0, b_i};
   end

   assign result_o = ext[W-1:0];
   assign carry_o  = ext[W];
   assign zero_o   = (ext[W-1:0] == '0);

endmodule

// File: rtl/ac_control.sv
// Fetch/decode/execute sequencer: owns PC, IR, ACC and {C,Z}, and drives the program ram port.
module ac_control
   import ac_pkg::*;
#(
   parameter int unsigned DATA_W = AC_DATA_W,
   parameter int unsigned ADDR_W = AC_ADDR_W,
   parameter int unsigned OPC_W  = AC_OPC_W
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              run_i,
   input  logic [DATA_W-1:0] mem_dout_i,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_wen_o,
   output logic [DATA_W-1:0] mem_din_o,
   output logic [DATA_W-1:0] acc_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic [1:0]        flags_o,
   output logic              halted_o
);

   state_e            state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [DATA_W-1:0] ir_q;
   logic [DATA_W-1:0] acc_q;
   logic              c_q;
   logic              z_q;

   logic [OPC_W-1:0]  dec_opc;
   logic [ADDR_W-1:0] dec_addr;
   logic [OPC_W-1:0]  ir_opc;
   logic [ADDR_W-1:0] ir_addr;
   logic [ADDR_W-1:0] pc_inc;

   logic [DATA_W-1:0] alu_res;
   logic              alu_c;
   logic              alu_z;
   logic              alu_sub;

   // DECODE sees the fetched word on the ram output before it lands in IR.
   assign dec_opc  = mem_dout_i[DATA_W-1 -: OPC_W];
   assign dec_addr = mem_dout_i[ADDR_W-1:0];
   assign ir_opc   = ir_q[DATA_W-1 -: OPC_W];
   assign ir_addr  = ir_q[ADDR_W-1:0];
   assign pc_inc   = pc_q + ADDR_W'(1);
   assign alu_sub  = (ir_opc == OP_SUB);

   ac_alu #(
      .W(DATA_W)
   ) u_alu (
      .a_i     (acc_q),
      .b_i     (mem_dout_i),
      .sub_i   (alu_sub),
      .result_o(alu_res),
      .carry_o (alu_c),
      .zero_o  (alu_z)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
         acc_q   <= '0;
         c_q     <= 1'b0;
         z_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (run_i) state_q <= ST_FETCH;
            end
            ST_FETCH: begin
               state_q <= ST_DECODE;
            end
            ST_DECODE: begin
               ir_q    <= mem_dout_i;
               pc_q    <= pc_inc;
               state_q <= ST_FETCH;
               case (dec_opc)
                  OP_JMP: pc_q <= dec_addr;
                  OP_JZ:  if (z_q) pc_q <= dec_addr;
                  OP_LDA, OP_ADD, OP_SUB: state_q <= ST_MEM_RD;
                  OP_STA: state_q <= ST_MEM_WR;
                  OP_HLT: state_q <= ST_HALT;
                  default: ;
               endcase
            end
            ST_MEM_RD: begin
               state_q <= ST_EXEC;
            end
            ST_EXEC: begin
               state_q <= ST_FETCH;
               case (ir_opc)
                  OP_LDA: begin
                     acc_q <= mem_dout_i;
                     z_q   <= (mem_dout_i == '0);
                  end
                  OP_ADD, OP_SUB: begin
                     acc_q <= alu_res;
                     c_q   <= alu_c;
                     z_q   <= alu_z;
                  end
                  default: ;
               endcase
            end
            ST_MEM_WR: begin
               state_q <= ST_FETCH;
            end
            ST_HALT: begin
               state_q <= ST_HALT;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Moore decode of the ram port; reset forces ST_IDLE so a pending write is dropped at once.
   always_comb begin
      mem_addr_o = pc_q;
      mem_wen_o  = 1'b0;
      mem_din_o  = '0;
      case (state_q)
         ST_MEM_RD: mem_addr_o = ir_addr;
         ST_MEM_WR: begin
            mem_addr_o = ir_addr;
            mem_wen_o  = 1'b1;
            mem_din_o  = acc_q;
         end
         default: ;
      endcase
   end

   assign acc_o    = acc_q;
   assign pc_o     = pc_q;
   assign flags_o  = {c_q, z_q};
   assign halted_o = (state_q == ST_HALT);

endmodule
